// File: rtl/ula_pkg.sv
// ula_pkg: ALUOp/funct encodings, arbiter FSM states and the shared R-type funct legality check
package ula_pkg;
    localparam logic [3:0] RTYPE = 4'b1111;
    localparam logic [3:0] BEQ   = 4'b0100;
    localparam logic [3:0] BNE   = 4'b0101;
    localparam logic [3:0] ADDI  = 4'b1000;
    localparam logic [3:0] SLTI  = 4'b1010;
    localparam logic [3:0] SLTIU = 4'b1011;
    localparam logic [3:0] ANDI  = 4'b1100;
    localparam logic [3:0] ORI   = 4'b1101;
    localparam logic [3:0] XORI  = 4'b1110;
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    function automatic logic is_valid_funct(input logic [5:0] funct);
        return funct inside {F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_ADD, F_SUB,
                             F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU};
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; on contention the port not granted last time wins
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);
    always_comb grant = (&req) ? ~last_grant : (req[1] & ~req[0]);
endmodule

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin sharing of the ula_ctrl/ALU pair between two requesters
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_aluop,
    input  logic [5:0]        req0_funct,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_aluop,
    input  logic [5:0]        req1_funct,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [3:0]        alu_aluop_o,
    output logic [5:0]        alu_funct_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              busy
);
    state_t            state;
    logic              last_grant, cur_id, grant, accept, bad_funct;
    logic [3:0]        op_aluop;
    logic [5:0]        op_funct;
    logic [DATA_W-1:0] op_a, op_b;
    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );
    always_comb begin
        req0_ready  = state == IDLE && req0_valid && !grant;
        req1_ready  = state == IDLE && req1_valid && grant;
        accept      = req0_ready || req1_ready;
        bad_funct   = op_aluop == RTYPE && !is_valid_funct(op_funct);
        rsp0_valid  = state == RESP && !cur_id;
        rsp1_valid  = state == RESP && cur_id;
        busy        = state != IDLE;
        alu_aluop_o = op_aluop;
        alu_funct_o = op_funct;
        alu_a_o     = op_a;
        alu_b_o     = op_b;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            op_aluop   <= '0;
            op_funct   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_aluop   <= grant ? req1_aluop : req0_aluop;
                    op_funct   <= grant ? req1_funct : req0_funct;
                    op_a       <= grant ? req1_a : req0_a;
                    op_b       <= grant ? req1_b : req0_b;
                    cur_id     <= grant;
                    last_grant <= grant;
                    state      <= EXEC;
                end
                EXEC: begin
                    rsp_err    <= bad_funct;
                    rsp_result <= bad_funct ? '0 : alu_result_i;
                    rsp_zero   <= !bad_funct && alu_zero_i;
                    state      <= RESP;
                end
                RESP: if (cur_id ? rsp1_ready : rsp0_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Shares the single ULA datapath (ula_ctrl plus ALU) between two requesters: port 0 is the main datapath and port 1 is an auxiliary unit, such as branch or address calculation.
- Each requester presents an ALUOp/funct/operand pair over a valid/ready handshake.
- The arbiter grants round-robin, registers the operands, drives the shared ULA, captures the result, and returns it over a per-requester response handshake.
- It sits between the control/issue logic and the ula_ctrl/ALU pair, and is the only driver of their inputs.

Parameters:
DATA_W, 32, operand/result width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_aluop  input  4  ALUOp code (same encoding as ula_ctrl)
req0_funct  input  6  funct field, meaningful when aluop=4'b1111
req0_a  input  DATA_W  operand A
req0_b  input  DATA_W  operand B
req1_valid, req1_ready, req1_aluop, req1_funct, req1_a, req1_b  same as port 0, for requester 1
rsp0_valid  output  1  result available for requester 0
rsp0_ready  input  1  requester 0 takes result
rsp1_valid  output  1  result available for requester 1
rsp1_ready  input  1  requester 1 takes result
rsp_result  output  DATA_W  registered ALU result (shared by both responses)
rsp_zero  output  1  registered ALU zero flag
rsp_err  output  1  unsupported R-type funct
alu_aluop_o  output  4  to ula_ctrl ALUOp
alu_funct_o  output  6  to ula_ctrl funct
alu_a_o  output  DATA_W  to ALU operand A
alu_b_o  output  DATA_W  to ALU operand B
alu_result_i  input  DATA_W  ALU result (combinational from alu_*_o)
alu_zero_i  input  1  ALU zero flag
busy  output  1  state != IDLE

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low (rst_n sampled on the clk rising edge).
  - With rst_n=0 at an edge: state=IDLE, last_grant=1 (so port 0 wins first), and all operand/result registers are 0.
  - Reset values of outputs: rsp*_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0, alu_aluop_o=4'b0000, alu_funct_o=0, alu_a_o=0, alu_b_o=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the only valid requester; if both are valid, the requester != last_grant.
  - reqX_ready = (state==IDLE) && reqX_valid && grant==X. This is combinational, and at most one ready is high.
  - On accept: latch aluop, funct, a and b into the op registers; cur_id<=grant; last_grant<=grant; go to EXEC.
  - With no valid requester, stay in IDLE.
- EXEC:
  - alu_*_o are driven directly from the op registers; they are stable from this cycle until the next accept.
  - At the end of the cycle, capture rsp_result<=alu_result_i and rsp_zero<=alu_zero_i, then go to RESP.
  - rsp_err<=1 when aluop==4'b1111 and funct is not one of: 00,02,03,04,06,07,20,22,24,25,26,27,2A,2B (hex). In that case rsp_result<=0 and rsp_zero<=0 instead of the ALU values.
- RESP:
  - rsp{cur_id}_valid=1; the other response valid stays 0.
  - rsp_result, rsp_zero and rsp_err are held stable.
  - When rsp{cur_id}_ready=1, go to IDLE. Responses to the other port's ready are ignored.
  - rsp_* data retain their last value in IDLE/EXEC; only the valids are qualified by state.
- Timing:
  - Latency: accept at cycle N, rsp valid at N+2.
  - Peak throughput: one op per 3 cycles.
  - No new request is accepted until the response handshake completes.
- Requester contract: payload is held stable while valid && !ready. The arbiter samples only on accept.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1... A single requester may be granted back-to-back if the other is idle.
- Reset mid-operation (rst_n=0 in EXEC or RESP): the operation is dropped, no response is issued, and all reset values apply on the next cycle.
- The arbiter performs no arithmetic; width rules belong to the ALU. Operands pass through unmodified.

Decomposition:
- Shared package ula_pkg holds:
  - ALUOp constants: RTYPE=4'b1111, BEQ=4'b0100, BNE=4'b0101, ADDI=4'b1000, SLTI=4'b1010, SLTIU=4'b1011, ANDI=4'b1100, ORI=4'b1101, XORI=4'b1110.
  - The funct constants for the 14 supported R-type ops.
  - The FSM state encoding (IDLE/EXEC/RESP).
  - A function is_valid_funct(funct), so that ula_ctrl and this block share one list.
- Sub-module rr_arb2: inputs req[1:0] and last_grant; output grant. Purely combinational, instantiated once.

Test Plan:
- Single op: req0 ADD (aluop=F, funct=20, a=5, b=7), ALU model returns 12 → req0_ready high in the IDLE cycle; rsp0_valid two cycles later with rsp_result=12, zero=0, err=0; rsp1_valid stays 0.
- Contention:
  - Stimulus: req0 and req1 both valid from reset, each SUB (funct=22), with port 1 given a=b=3.
  - Required: port 0 served first, then port 1 (rsp_zero=1), then port 0 again.
  - Grants must alternate over 6 ops.
- Backpressure: hold rsp1_ready=0 for 4 cycles → rsp1_valid and rsp_result stay stable; req0_ready stays 0 throughout; IDLE is re-entered the cycle after ready=1.
- Bad funct: req1 aluop=F, funct=3F → rsp_err=1, rsp_result=0; the next legal op clears err.
- Reset mid-op: assert rst_n=0 during EXEC → next cycle busy=0, rsp*_valid=0, alu_*_o=0, and port 0 wins the next grant.
- Non-R op: req0 ORI (aluop=D, a=32'h00F0, b=32'h000F) → alu_aluop_o=D during EXEC; rsp_result equals the model output 32'h00FF.
